// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared state encoding and descriptor layout for the command sequencer
package cmd_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_DISPATCH, S_WAIT, S_DONE
    } state_t;
    localparam int CMD_WORDS  = 5;
    localparam int W_HDR      = 0;
    localparam int W_CH       = 1;
    localparam int W_WBASE    = 2;
    localparam int W_RADDR    = 3;
    localparam int W_WADDR    = 4;
    localparam int OP_LSB     = 0;
    localparam int STRIDE_LSB = 8;
    localparam int OUT_CH_LSB = 16;
    function automatic logic [7:0] op_type(input logic [31:0] w);
        return w[OP_LSB +: 8];
    endfunction
    function automatic logic [7:0] stride_of(input logic [31:0] w);
        return w[STRIDE_LSB +: 8];
    endfunction
endpackage

// File: rtl/cmd_sequencer_if.sv
// cmd_sequencer_if: cmd FIFO, engine go/done and decoded descriptor bus
interface cmd_sequencer_if #(
    parameter int NUM_ENGINES = 4,
    parameter int ADDR_W      = 32,
    parameter int CH_W        = 16
);
    logic                   cmd_fifo_rd_en;
    logic [31:0]            cmd;
    logic                   cmd_fifo_empty;
    logic [NUM_ENGINES-1:0] eng_go;
    logic [NUM_ENGINES-1:0] eng_done;
    logic [7:0]             stride;
    logic [CH_W-1:0]        in_ch;
    logic [CH_W-1:0]        out_ch;
    logic [ADDR_W-1:0]      w_base;
    logic [ADDR_W-1:0]      r_addr;
    logic [ADDR_W-1:0]      w_addr;
    modport master (
        output cmd_fifo_rd_en, eng_go, stride, in_ch, out_ch, w_base, r_addr, w_addr,
        input  cmd, cmd_fifo_empty, eng_done
    );
    modport slave (
        input  cmd_fifo_rd_en, eng_go, stride, in_ch, out_ch, w_base, r_addr, w_addr,
        output cmd, cmd_fifo_empty, eng_done
    );
endinterface

// File: rtl/cmd_fetch.sv
// cmd_fetch: pops five FIFO words per descriptor and captures each one cycle after its pop
module cmd_fetch
    import cmd_seq_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         empty,
    input  logic [31:0]                  cmd,
    output logic                         rd_en,
    output logic                         done,
    output logic [CMD_WORDS-1:0][31:0]   words
);
    logic [2:0] req_cnt;
    logic [2:0] cap_cnt;
    logic       cap;

    assign rd_en = en && !empty && req_cnt < 3'(CMD_WORDS);
    assign done  = cap && cap_cnt == 3'(CMD_WORDS - 1);

    // Pop/capture counters; an empty FIFO simply withholds pops so nothing is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt <= '0;
            cap_cnt <= '0;
            cap     <= 1'b0;
            words   <= '0;
        end else begin
            cap     <= rd_en;
            req_cnt <= done ? '0 : req_cnt + 3'(rd_en);
            if (cap) begin
                words[cap_cnt] <= cmd;
                cap_cnt        <= done ? '0 : cap_cnt + 3'd1;
            end
        end
    end
endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: descriptor fetch/decode/dispatch FSM; CMD_SEQ_PERF_EN adds a busy-cycle counter
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int ADDR_W      = 32,
    parameter int CH_W        = 16,
    parameter int SIZE_W      = 7
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_en,
    input  logic [SIZE_W-1:0] cmd_size,
    cmd_sequencer_if.master   bus,
    output logic              busy,
    output logic              err,
`ifdef CMD_SEQ_PERF_EN
    output logic              irq,
    output logic [31:0]       perf_cycles
`else
    output logic              irq
`endif
);
    localparam int ENG_W = NUM_ENGINES > 1 ? $clog2(NUM_ENGINES) : 1;

    state_t                       state, nxt;
    logic [CMD_WORDS-1:0][31:0]   words;
    logic                         fetch_done, legal, last, start, done_hit;
    logic [SIZE_W-1:0]            size_q, desc_cnt, desc_nxt;
    logic [ENG_W-1:0]             eng_sel;
    logic [7:0]                   op;
    logic                         unused_hdr;

    cmd_fetch u_fetch (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == S_FETCH),
        .empty (bus.cmd_fifo_empty),
        .cmd   (bus.cmd),
        .rd_en (bus.cmd_fifo_rd_en),
        .done  (fetch_done),
        .words (words)
    );

    assign op         = op_type(words[W_HDR]);
    assign legal      = int'(op) < NUM_ENGINES;
    assign desc_nxt   = desc_cnt + SIZE_W'(1);
    assign last       = desc_nxt == size_q;
    assign start      = state == S_IDLE && op_en;
    assign done_hit   = bus.eng_done[eng_sel];
    assign unused_hdr = ^words[W_HDR][31:16];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next state and state-decoded outputs; done from a non-target engine never matches done_hit
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:     nxt = !op_en ? S_IDLE : (cmd_size == '0 ? S_DONE : S_FETCH);
            S_FETCH:    nxt = fetch_done ? S_DECODE : S_FETCH;
            S_DECODE:   nxt = legal ? S_DISPATCH : (last ? S_DONE : S_FETCH);
            S_DISPATCH: nxt = S_WAIT;
            S_WAIT:     nxt = !done_hit ? S_WAIT : (last ? S_DONE : S_FETCH);
            S_DONE:     nxt = op_en ? S_DONE : S_IDLE;
            default:    nxt = S_IDLE;
        endcase
        bus.eng_go = state == S_DISPATCH ? NUM_ENGINES'(1) << eng_sel : '0;
        busy       = !(state inside {S_IDLE, S_DONE});
        irq        = state == S_DONE;
    end

    // Run bookkeeping and decoded fields, held stable from DECODE until the next DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q     <= '0;
            desc_cnt   <= '0;
            err        <= 1'b0;
            eng_sel    <= '0;
            bus.stride <= '0;
            bus.in_ch  <= '0;
            bus.out_ch <= '0;
            bus.w_base <= '0;
            bus.r_addr <= '0;
            bus.w_addr <= '0;
        end else begin
            if (start) begin
                size_q   <= cmd_size;
                desc_cnt <= '0;
                err      <= 1'b0;
            end
            if (state == S_DECODE) begin
                eng_sel    <= op[ENG_W-1:0];
                bus.stride <= stride_of(words[W_HDR]);
                bus.in_ch  <= CH_W'(words[W_CH]);
                bus.out_ch <= CH_W'(words[W_CH] >> OUT_CH_LSB);
                bus.w_base <= ADDR_W'(words[W_WBASE]);
                bus.r_addr <= ADDR_W'(words[W_RADDR]);
                bus.w_addr <= ADDR_W'(words[W_WADDR]);
                if (!legal) begin
                    err      <= 1'b1;
                    desc_cnt <= desc_nxt;
                end
            end
            if (state == S_WAIT && done_hit) desc_cnt <= desc_nxt;
        end
    end

`ifdef CMD_SEQ_PERF_EN
    // Saturating count of busy cycles, restarted with each run and frozen in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            perf_cycles <= '0;
        else if (start)                        perf_cycles <= '0;
        else if (busy && perf_cycles != '1)    perf_cycles <= perf_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: table-driven descriptor runs plus hand-written reset, stall and spurious-done sequences
module tb_cmd_sequencer;
    import cmd_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_en = 1'b0;
    logic [6:0] cmd_size = '0;
    logic       busy, err, irq;
`ifdef CMD_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    cmd_sequencer_if #(.NUM_ENGINES(4), .ADDR_W(32), .CH_W(16)) bus();

    cmd_sequencer #(.NUM_ENGINES(4), .ADDR_W(32), .CH_W(16), .SIZE_W(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_en    (op_en),
        .cmd_size (cmd_size),
        .bus      (bus),
        .busy     (busy),
        .err      (err),
`ifdef CMD_SEQ_PERF_EN
        .irq         (irq),
        .perf_cycles (perf_cycles)
`else
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0][31:0] w;
        int               dly;
        logic [3:0]       go;
        logic [7:0]       stride;
        logic [15:0]      in_ch;
        logic [15:0]      out_ch;
        logic [31:0]      w_base;
        logic [31:0]      r_addr;
        logic [31:0]      w_addr;
    } vec_t;

    vec_t tbl[6];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [31:0] mem[256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        stall = 1'b0;
    logic        stall_mode = 1'b0;
    logic [3:0]  done_r = '0;
    logic [3:0]  spur = '0;
    logic [3:0]  tgt = '0;
    int          cd = 0;
    int          exp_dly[64];
    int          go_n = 0, dn = 0, pops = 0, busy_n = 0;
    logic [3:0]  s_go[64];
    logic [7:0]  s_str[64];
    logic [15:0] s_in[64], s_out[64];
    logic [31:0] s_wb[64], s_ra[64], s_wa[64];

    assign bus.cmd_fifo_empty = (rd_ptr == wr_ptr) || stall;
    assign bus.eng_done       = done_r | spur;

    // FIFO model: read data appears the cycle after a pop
    always @(posedge clk) begin
        if (bus.cmd_fifo_rd_en) begin
            bus.cmd <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Engine model and monitors, sampled away from the active edge
    always @(negedge clk) begin
        done_r = '0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                done_r = tgt;
                dn = dn + 1;
            end
        end
        if (bus.eng_go != '0) begin
            s_go[go_n]  = bus.eng_go;
            s_str[go_n] = bus.stride;
            s_in[go_n]  = bus.in_ch;
            s_out[go_n] = bus.out_ch;
            s_wb[go_n]  = bus.w_base;
            s_ra[go_n]  = bus.r_addr;
            s_wa[go_n]  = bus.w_addr;
            tgt         = bus.eng_go;
            cd          = exp_dly[go_n];
            go_n        = go_n + 1;
        end
        if (bus.cmd_fifo_rd_en) pops = pops + 1;
        if (busy) busy_n = busy_n + 1;
        stall = stall_mode & ~stall;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic defv(input int i, input logic [31:0] w0, w1, w2, w3, w4, input int dly,
                        input logic [3:0] go, input logic [7:0] st, input logic [15:0] ic, oc,
                        input logic [31:0] wb, ra, wa);
        tbl[i].w      = {w4, w3, w2, w1, w0};
        tbl[i].dly    = dly;
        tbl[i].go     = go;
        tbl[i].stride = st;
        tbl[i].in_ch  = ic;
        tbl[i].out_ch = oc;
        tbl[i].w_base = wb;
        tbl[i].r_addr = ra;
        tbl[i].w_addr = wa;
    endtask

    task automatic load(input int i);
        for (int k = 0; k < 5; k++) begin
            mem[wr_ptr] = tbl[i].w[k];
            wr_ptr++;
        end
    endtask

    task automatic wait_go(input int g, input string nm);
        int t;
        t = 0;
        while (go_n == g && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({nm, ".go_seen"}, 32'(go_n - g), 32'd1);
    endtask

    task automatic run(input string nm, input int sz, input int ix0, ix1, ix2, input bit early);
        int ix[3];
        int leg[3];
        int g0, d0, p0, b0, nleg;
        ix = '{ix0, ix1, ix2};
        g0 = go_n; d0 = dn; p0 = pops; b0 = busy_n; nleg = 0;
        for (int k = 0; k < sz; k++) begin
            load(ix[k]);
            if (tbl[ix[k]].go != '0) begin
                exp_dly[g0 + nleg] = tbl[ix[k]].dly;
                leg[nleg] = ix[k];
                nleg++;
            end
        end
        @(negedge clk);
        cmd_size = 7'(sz);
        op_en    = 1'b1;
        if (early) begin
            repeat (3) @(negedge clk);
            op_en = 1'b0;
        end
        for (int i = 0; i < 4000 && !irq; i++) @(negedge clk);
        chk({nm, ".irq"}, 32'(irq), 32'd1);
        chk({nm, ".busy_done"}, 32'(busy), 32'd0);
        chk({nm, ".ngo"}, 32'(go_n - g0), 32'(nleg));
        chk({nm, ".done_before_irq"}, 32'(dn - d0), 32'(nleg));
        chk({nm, ".pops"}, 32'(pops - p0), 32'(5 * sz));
        for (int j = 0; j < nleg; j++) begin
            chk({nm, ".go"},     32'(s_go[g0 + j]),  32'(tbl[leg[j]].go));
            chk({nm, ".stride"}, 32'(s_str[g0 + j]), 32'(tbl[leg[j]].stride));
            chk({nm, ".in_ch"},  32'(s_in[g0 + j]),  32'(tbl[leg[j]].in_ch));
            chk({nm, ".out_ch"}, 32'(s_out[g0 + j]), 32'(tbl[leg[j]].out_ch));
            chk({nm, ".w_base"}, s_wb[g0 + j], tbl[leg[j]].w_base);
            chk({nm, ".r_addr"}, s_ra[g0 + j], tbl[leg[j]].r_addr);
            chk({nm, ".w_addr"}, s_wa[g0 + j], tbl[leg[j]].w_addr);
        end
`ifdef CMD_SEQ_PERF_EN
        chk({nm, ".perf"}, perf_cycles, 32'(busy_n - b0));
`endif
        op_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, ".irq_clear"}, 32'(irq), 32'd0);
    endtask

    initial begin
        int g;
        defv(0, 32'hc400_e001, 32'h0040_0003, 32'h0000_1000, 32'h0029_0000, 32'h002e_0000, 50,
             4'b0010, 8'he0, 16'h0003, 16'h0040, 32'h0000_1000, 32'h0029_0000, 32'h002e_0000);
        defv(1, 32'h0000_0200, 32'h0010_0008, 32'h0000_a000, 32'h0000_b000, 32'h0000_c000, 3,
             4'b0001, 8'h02, 16'h0008, 16'h0010, 32'h0000_a000, 32'h0000_b000, 32'h0000_c000);
        defv(2, 32'h0000_1102, 32'h0020_0004, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1,
             4'b0100, 8'h11, 16'h0004, 16'h0020, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
        defv(3, 32'hffff_ff03, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, 32'h1234_5678, 5,
             4'b1000, 8'hff, 16'hffff, 16'hffff, 32'hffff_ffff, 32'h0000_0000, 32'h1234_5678);
        defv(4, 32'h0000_0507, 32'hdead_0001, 32'hdead_0002, 32'hdead_0003, 32'hdead_0004, 1,
             4'b0000, 8'h05, 16'h0001, 16'hdead, 32'hdead_0002, 32'hdead_0003, 32'hdead_0004);
        defv(5, 32'h0000_0401, 32'h0002_0001, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 4,
             4'b0010, 8'h04, 16'h0001, 16'h0002, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);

        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.irq", 32'(irq), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.eng_go", 32'(bus.eng_go), 32'd0);
        chk("rst.rd_en", 32'(bus.cmd_fifo_rd_en), 32'd0);
        chk("rst.r_addr", bus.r_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("single", 1, 0, 0, 0, 1'b0);
        run("mixed3", 3, 1, 2, 3, 1'b1);
        stall_mode = 1'b1;
        run("stall", 1, 3, 0, 0, 1'b0);
        stall_mode = 1'b0;
        run("illegal", 2, 4, 5, 0, 1'b0);
        chk("illegal.err", 32'(err), 32'd1);

        @(negedge clk);
        g = pops;
        cmd_size = '0;
        op_en = 1'b1;
        @(negedge clk);
        chk("size0.busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("size0.irq", 32'(irq), 32'd1);
        chk("size0.err_cleared", 32'(err), 32'd0);
        chk("size0.no_rd", 32'(pops - g), 32'd0);
`ifdef CMD_SEQ_PERF_EN
        chk("size0.perf", perf_cycles, 32'd0);
`endif
        op_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("size0.irq_clear", 32'(irq), 32'd0);

        g = go_n;
        fork
            run("spur", 1, 0, 0, 0, 1'b0);
            begin
                wait_go(g, "spur");
                repeat (10) @(negedge clk);
                spur = 4'b0001;
                @(negedge clk);
                spur = 4'b0000;
                @(negedge clk);
                chk("spur.irq_low", 32'(irq), 32'd0);
                chk("spur.busy", 32'(busy), 32'd1);
            end
        join

        g = go_n;
        load(0);
        exp_dly[g] = 50;
        @(negedge clk);
        cmd_size = 7'd1;
        op_en = 1'b1;
        wait_go(g, "rstwait");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwait.busy", 32'(busy), 32'd0);
        chk("rstwait.irq", 32'(irq), 32'd0);
        chk("rstwait.stride", 32'(bus.stride), 32'd0);
        chk("rstwait.in_ch", 32'(bus.in_ch), 32'd0);
        chk("rstwait.out_ch", 32'(bus.out_ch), 32'd0);
        chk("rstwait.w_base", bus.w_base, 32'd0);
        chk("rstwait.r_addr", bus.r_addr, 32'd0);
        chk("rstwait.w_addr", bus.w_addr, 32'd0);
        chk("rstwait.eng_go", 32'(bus.eng_go), 32'd0);
`ifdef CMD_SEQ_PERF_EN
        chk("rstwait.perf", perf_cycles, 32'd0);
`endif
        op_en = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst.busy", 32'(busy), 32'd0);
        chk("post_rst.irq", 32'(irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
